// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master command port and the register-access sequencer.
package i2c_pkg;

    localparam logic [2:0] START_CMD   = 3'd0;
    localparam logic [2:0] WR_CMD      = 3'd1;
    localparam logic [2:0] RD_CMD      = 3'd2;
    localparam logic [2:0] STOP_CMD    = 3'd3;
    localparam logic [2:0] RESTART_CMD = 3'd4;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_DEV  = 2'd1;
    localparam logic [1:0] ERR_REG  = 2'd2;
    localparam logic [1:0] ERR_DATA = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DEV_W,
        ST_REG,
        ST_WDATA,
        ST_RESTART,
        ST_DEV_R,
        ST_READ,
        ST_STOP,
        ST_DONE
    } seq_state_t;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } seq_phase_t;

endpackage

// File: rtl/i2c_reg_seq.sv
// Sequences START/address/register/data/RESTART/STOP commands into i2c_master
// to perform one single-byte register write or read per request.
module i2c_reg_seq
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [2:0] m_cmd,
    output logic [7:0] m_din,
    output logic       m_wr_i2c,
    input  logic       m_ready,
    input  logic       m_done_tick,
    input  logic       m_ack,
    input  logic [7:0] m_dout
);

    seq_state_t state;
    seq_phase_t phase;
    logic       settle;
    logic       rw;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       nack;
    logic [7:0] rbuf;
    logic       rd_ok;
    logic [1:0] err;

    logic [2:0] issue_cmd;
    logic [7:0] issue_din;
    logic       xfer;
    logic       nack_now;
    logic [7:0] dout_now;

    always_comb begin
        issue_cmd = START_CMD;
        issue_din = '0;
        case (state)
            ST_DEV_W:   begin issue_cmd = WR_CMD;      issue_din = {dev, 1'b0}; end
            ST_REG:     begin issue_cmd = WR_CMD;      issue_din = reg_addr;    end
            ST_WDATA:   begin issue_cmd = WR_CMD;      issue_din = wdata;       end
            ST_RESTART: begin issue_cmd = RESTART_CMD;                          end
            ST_DEV_R:   begin issue_cmd = WR_CMD;      issue_din = {dev, 1'b1}; end
            ST_READ:    begin issue_cmd = RD_CMD;      issue_din = 8'h01;       end
            ST_STOP:    begin issue_cmd = STOP_CMD;                             end
            default:    ;
        endcase
    end

    // The done tick may coincide with m_ready rising, so decisions use the live value.
    always_comb begin
        xfer     = state inside {ST_DEV_W, ST_REG, ST_WDATA, ST_DEV_R, ST_READ};
        nack_now = (m_done_tick && xfer) ? m_ack : nack;
        dout_now = (m_done_tick && state == ST_READ) ? m_dout : rbuf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= PH_ISSUE;
            settle    <= 1'b0;
            rw        <= 1'b0;
            dev       <= '0;
            reg_addr  <= '0;
            wdata     <= '0;
            nack      <= 1'b0;
            rbuf      <= '0;
            rd_ok     <= 1'b0;
            err       <= ERR_OK;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            m_cmd     <= START_CMD;
            m_din     <= '0;
            m_wr_i2c  <= 1'b0;
        end else begin
            m_wr_i2c  <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rw        <= req_rw;
                        dev       <= req_dev;
                        reg_addr  <= req_reg;
                        wdata     <= req_wdata;
                        err       <= ERR_OK;
                        rd_ok     <= 1'b0;
                        req_ready <= 1'b0;
                        phase     <= PH_ISSUE;
                        state     <= ST_START;
                    end
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    if (phase == PH_ISSUE) begin
                        if (m_ready) begin
                            m_cmd    <= issue_cmd;
                            m_din    <= issue_din;
                            m_wr_i2c <= 1'b1;
                            nack     <= 1'b0;
                            settle   <= 1'b1;
                            phase    <= PH_WAIT;
                        end
                    end else begin
                        // First WAIT cycle: the master has not yet dropped m_ready.
                        settle <= 1'b0;
                        if (m_done_tick && xfer) begin
                            nack <= m_ack;
                            if (state == ST_READ)
                                rbuf <= m_dout;
                        end
                        if (!settle && m_ready) begin
                            phase <= PH_ISSUE;
                            case (state)
                                ST_START: state <= ST_DEV_W;
                                ST_DEV_W: begin
                                    if (nack_now) begin
                                        err   <= ERR_DEV;
                                        state <= ST_STOP;
                                    end else begin
                                        state <= ST_REG;
                                    end
                                end
                                ST_REG: begin
                                    if (nack_now) begin
                                        err   <= ERR_REG;
                                        state <= ST_STOP;
                                    end else begin
                                        state <= rw ? ST_RESTART : ST_WDATA;
                                    end
                                end
                                ST_WDATA: begin
                                    if (nack_now)
                                        err <= ERR_DATA;
                                    state <= ST_STOP;
                                end
                                ST_RESTART: state <= ST_DEV_R;
                                ST_DEV_R: begin
                                    if (nack_now) begin
                                        err   <= ERR_DEV;
                                        state <= ST_STOP;
                                    end else begin
                                        state <= ST_READ;
                                    end
                                end
                                ST_READ: begin
                                    rbuf  <= dout_now;
                                    rd_ok <= 1'b1;
                                    state <= ST_STOP;
                                end
                                ST_STOP: begin
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= err;
                                    if (rd_ok)
                                        rsp_rdata <= rbuf;
                                    state <= ST_DONE;
                                end
                                default: state <= ST_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
